// File: rtl/multiboot_sequencer.sv
// Multiboot sequencer: qualifies PLL lock before releasing sys_reset, then runs
// USB detach and a SB_WARMBOOT boot pulse for a selected image on request.
module multiboot_sequencer #(
  parameter int IMAGE_COUNT      = 4,
  parameter int DEFAULT_IMAGE    = 1,
  parameter int LOCK_CYCLES      = 1024,
  parameter int DETACH_CYCLES    = 480000,
  parameter int BOOT_HOLD_CYCLES = 4,
  parameter int CNT_W            = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  output logic       sys_reset,
  input  logic       req_valid,
  input  logic       req_auto,
  input  logic [1:0] req_image,
  output logic       req_ready,
  output logic       req_err,
  output logic       usb_pu,
  output logic [1:0] boot_sel,
  output logic       boot,
  output logic       busy
);

  typedef enum logic [1:0] {LOCKWAIT, IDLE, DETACH, BOOT} state_t;

  localparam logic [CNT_W-1:0] LOCK_MAX    = CNT_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] DETACH_LAST = CNT_W'(DETACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX    = CNT_W'(BOOT_HOLD_CYCLES);
  localparam logic [1:0]       DEF_IMG     = 2'(DEFAULT_IMAGE);
  localparam logic [2:0]       IMG_LIMIT   = 3'(IMAGE_COUNT);

  logic             lock_meta;
  logic             lock_s;
  logic [CNT_W-1:0] lock_cnt;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       sel_next;
  logic [1:0]       req_idx;
  logic             err_next;
  logic             boot_next;

  // sys_reset rises the cycle after any unlocked sample, falls once the count saturates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      lock_cnt  <= '0;
      sys_reset <= 1'b1;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      if (!lock_s)
        lock_cnt <= '0;
      else if (lock_cnt != LOCK_MAX)
        lock_cnt <= lock_cnt + CNT_W'(1);
      sys_reset <= !(lock_s && (lock_cnt == LOCK_MAX));
    end
  end

  assign req_ready = (state == IDLE) && !sys_reset;
  assign req_idx   = req_auto ? DEF_IMG : req_image;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sel_next   = boot_sel;
    err_next   = 1'b0;
    case (state)
      LOCKWAIT: begin
        cnt_next = '0;
        if (!sys_reset)
          state_next = IDLE;
      end
      IDLE: begin
        if (req_valid && req_ready) begin
          if ({1'b0, req_idx} >= IMG_LIMIT) begin
            err_next = 1'b1;
          end else begin
            sel_next   = req_idx;
            cnt_next   = '0;
            state_next = DETACH;
          end
        end
      end
      DETACH: begin
        if (cnt == DETACH_LAST) begin
          cnt_next   = '0;
          state_next = BOOT;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      BOOT: begin
        if (cnt != HOLD_MAX)
          cnt_next = cnt + CNT_W'(1);
      end
      default: state_next = LOCKWAIT;
    endcase
    // Lock loss wins over everything and keeps the previously selected image
    if (!lock_s) begin
      state_next = LOCKWAIT;
      cnt_next   = '0;
      sel_next   = boot_sel;
      err_next   = 1'b0;
    end
    boot_next = (state_next == BOOT) && (cnt_next != HOLD_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= LOCKWAIT;
      cnt      <= '0;
      usb_pu   <= 1'b0;
      boot     <= 1'b0;
      boot_sel <= DEF_IMG;
      req_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      usb_pu   <= (state_next == IDLE);
      boot     <= boot_next;
      boot_sel <= sel_next;
      req_err  <= err_next;
      busy     <= (state_next == DETACH) || (state_next == BOOT);
    end
  end

endmodule

// File: tb/tb_multiboot_sequencer.sv
// Self-checking bench for multiboot_sequencer: lock qualification, request
// acceptance/rejection via a scoreboard, detach/boot timing and aborts.
`timescale 1ns/1ps
module tb_multiboot_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_lock;
  logic       sys_reset;
  logic       req_valid;
  logic       req_auto;
  logic [1:0] req_image;
  logic       req_ready;
  logic       req_err;
  logic       usb_pu;
  logic [1:0] boot_sel;
  logic       boot;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       err;
    logic [1:0] img;
  } exp_t;
  exp_t sb[$];

  multiboot_sequencer #(
    .IMAGE_COUNT(3), .DEFAULT_IMAGE(1), .LOCK_CYCLES(8),
    .DETACH_CYCLES(16), .BOOT_HOLD_CYCLES(4), .CNT_W(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .sys_reset(sys_reset),
    .req_valid(req_valid), .req_auto(req_auto), .req_image(req_image),
    .req_ready(req_ready), .req_err(req_err), .usb_pu(usb_pu),
    .boot_sel(boot_sel), .boot(boot), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decision for a request: IMAGE_COUNT=3, DEFAULT_IMAGE=1
  function automatic exp_t model(input logic a, input logic [1:0] img);
    exp_t e;
    e.img = a ? 2'd1 : img;
    e.err = (e.img >= 2'd3);
    return e;
  endfunction

  task automatic issue_request(input logic a, input logic [1:0] img);
    req_valid = 1'b1;
    req_auto  = a;
    req_image = img;
    sb.push_back(model(a, img));
    tick();
    req_valid = 1'b0;
    req_auto  = 1'b0;
  endtask

  task automatic collect_result(input string name);
    exp_t e;
    int i;
    for (i = 0; i < 4; i++) begin
      if (busy || req_err) break;
      tick();
    end
    e = sb.pop_front();
    checks++;
    if (i == 4) begin
      errors++;
      $display("[TB] FAIL %s_timeout: no busy/req_err within 4 cycles", name);
    end else if (req_err !== e.err) begin
      errors++;
      $display("[TB] FAIL %s_err: got %b expected %b", name, req_err, e.err);
    end else if (!e.err && boot_sel !== e.img) begin
      errors++;
      $display("[TB] FAIL %s_sel: got %0d expected %0d", name, boot_sel, e.img);
    end
  endtask

  task automatic relock(input string name);
    int i;
    pll_lock = 1'b1;
    for (i = 0; i < 40; i++) begin
      if (!sys_reset) break;
      tick();
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || usb_pu !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_relock: req_ready=%b usb_pu=%b expected 1/1", name, req_ready, usb_pu);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_lock = 1'b0; req_valid = 1'b0; req_auto = 1'b0; req_image = 2'd0;
    #12;
    checks++;
    if ({sys_reset, usb_pu, boot, boot_sel, req_ready, req_err, busy} !== {1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got sr=%b pu=%b boot=%b sel=%0d rdy=%b err=%b busy=%b expected 1 0 0 1 0 0 0",
               sys_reset, usb_pu, boot, boot_sel, req_ready, req_err, busy);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_lock_bringup();
    int n;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (sys_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unlocked_sys_reset: got %b expected 1", sys_reset);
    end
    pll_lock = 1'b1;
    for (n = 1; n <= 30; n++) begin
      tick();
      if (!sys_reset) break;
    end
    checks++;
    if (n != 11) begin
      errors++;
      $display("[TB] FAIL release_latency: got %0d expected 11", n);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_at_release: got %b expected 0", req_ready);
    end
    tick();
    checks++;
    if (usb_pu !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_entry: usb_pu=%b req_ready=%b expected 1/1", usb_pu, req_ready);
    end
  endtask

  task automatic test_lock_glitch();
    int n;
    int held;
    pll_lock = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (sys_reset !== 1'b1 || usb_pu !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lock_drop: sr=%b pu=%b rdy=%b expected 1 0 0", sys_reset, usb_pu, req_ready);
    end
    held = 1;
    pll_lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!sys_reset) held = 0;
    end
    pll_lock = 1'b0;
    tick();
    if (!sys_reset) held = 0;
    pll_lock = 1'b1;
    for (n = 1; n <= 30; n++) begin
      tick();
      if (!sys_reset) break;
    end
    checks++;
    if (held != 1 || n != 11) begin
      errors++;
      $display("[TB] FAIL glitch_restart: held=%0d latency=%0d expected 1 and 11", held, n);
    end
    tick();
  endtask

  task automatic test_bad_index();
    issue_request(1'b0, 2'd3);
    collect_result("bad_index");
    checks++;
    if (usb_pu !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_index_idle: pu=%b rdy=%b busy=%b expected 1 1 0", usb_pu, req_ready, busy);
    end
    tick();
    checks++;
    if (req_err !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_pulse_width: err=%b rdy=%b expected 0 1", req_err, req_ready);
    end
  endtask

  task automatic test_lock_loss_abort();
    int saw_boot;
    int i;
    issue_request(1'b0, 2'd2);
    collect_result("abort_req");
    for (int k = 0; k < 5; k++) tick();
    pll_lock = 1'b0;
    saw_boot = 0;
    for (i = 0; i < 10; i++) begin
      if (boot) saw_boot = 1;
      if (sys_reset) break;
      tick();
    end
    tick();
    if (boot) saw_boot = 1;
    checks++;
    if (i == 10 || saw_boot != 0 || boot_sel !== 2'd2 || usb_pu !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lock_abort: timeout=%0d boot_seen=%0d sel=%0d pu=%b busy=%b rdy=%b expected 0 0 2 0 0 0",
               (i == 10), saw_boot, boot_sel, usb_pu, busy, req_ready);
    end
  endtask

  task automatic test_auto_request();
    relock("auto");
    issue_request(1'b1, 2'd3);
    collect_result("auto_req");
    tick();
    req_valid = 1'b1; req_image = 2'd0;
    tick();
    req_valid = 1'b0;
    checks++;
    if (req_err !== 1'b0 || boot_sel !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignored_while_busy: err=%b sel=%0d busy=%b expected 0 1 1", req_err, boot_sel, busy);
    end
  endtask

  task automatic test_normal_reboot();
    int d;
    int h;
    int pu_bad;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    relock("normal");
    issue_request(1'b0, 2'd2);
    collect_result("normal_req");
    d = 1;
    pu_bad = usb_pu;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (boot) break;
      if (usb_pu) pu_bad = 1;
      d++;
    end
    checks++;
    if (d != 16 || pu_bad != 0) begin
      errors++;
      $display("[TB] FAIL detach_length: got %0d cycles (pu_bad=%0d) expected 16", d, pu_bad);
    end
    h = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!boot) break;
      h++;
    end
    checks++;
    if (h != 4) begin
      errors++;
      $display("[TB] FAIL boot_hold: got %0d cycles expected 4", h);
    end
    tick();
    checks++;
    if (boot !== 1'b0 || busy !== 1'b1 || usb_pu !== 1'b0 || boot_sel !== 2'd2 || req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL boot_terminal: boot=%b busy=%b pu=%b sel=%0d rdy=%b expected 0 1 0 2 0",
               boot, busy, usb_pu, boot_sel, req_ready);
    end
  endtask

  task automatic test_async_reset_mid_boot();
    int i;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    relock("async");
    issue_request(1'b0, 2'd0);
    collect_result("async_req");
    for (i = 0; i < 40; i++) begin
      if (boot) break;
      tick();
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (i == 40 || boot !== 1'b0 || sys_reset !== 1'b1 || boot_sel !== 2'd1 || usb_pu !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: timeout=%0d boot=%b sr=%b sel=%0d pu=%b busy=%b expected 0 0 1 1 0 0",
               (i == 40), boot, sys_reset, boot_sel, usb_pu, busy);
    end
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_bringup();
    test_lock_glitch();
    test_bad_index();
    test_lock_loss_abort();
    test_auto_request();
    test_normal_reboot();
    test_async_reset_mid_boot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiboot_sequencer.md
Name: multiboot_sequencer

Overview:
- Parametrised successor to the fixed single-image warmboot hookup: generalises to up to IMAGE_COUNT selectable images (drives SB_WARMBOOT S1/S0/BOOT).
- Adds a USB detach sequence: drops the D+ pull-up and holds for a detach period before rebooting, so the host sees a clean disconnect.
- Adds PLL-lock qualification: system reset is released only after lock has been stable for a programmed time.
- Sits in the board top between the PLL, the bootloader core and the warmboot primitive; runs on the 48 MHz USB clock.

Parameters:
- IMAGE_COUNT, 4, number of selectable images (1..4); req_image values >= IMAGE_COUNT are rejected.
- DEFAULT_IMAGE, 1, image selected on a zero-length/auto request (req_auto).
- LOCK_CYCLES, 1024, consecutive pll_lock=1 cycles required before sys_reset deasserts (>=1).
- DETACH_CYCLES, 480000, cycles usb_pu held low before boot (10 ms at 48 MHz, >=1).
- BOOT_HOLD_CYCLES, 4, cycles boot held high (>=1).
- CNT_W, 20, internal counter width; must hold max(LOCK_CYCLES, DETACH_CYCLES, BOOT_HOLD_CYCLES).

Ports:
- clk  input  1  Single clock for the block, the 48 MHz USB clock.
- reset_n  input  1  Asynchronous, active-low reset.
- pll_lock  input  1  PLL LOCK, asynchronous; synchronised internally with 2 flops.
- sys_reset  output  1  Active-high reset to the bootloader core.
- req_valid  input  1  Reboot request strobe.
- req_auto  input  1  Qualifies req_valid; when 1, use DEFAULT_IMAGE and ignore req_image.
- req_image  input  2  Requested image index.
- req_ready  output  1  High only in IDLE with sys_reset=0.
- req_err  output  1  One-cycle pulse when a request is rejected.
- usb_pu  output  1  USB D+ pull-up enable.
- boot_sel  output  2  To SB_WARMBOOT {S1,S0}.
- boot  output  1  To SB_WARMBOOT BOOT.
- busy  output  1  High in DETACH or BOOT.

Behaviour:
- Reset values (reset_n=0, asynchronous):
  - Outputs: sys_reset=1, usb_pu=0, boot=0, boot_sel=DEFAULT_IMAGE, req_ready=0, req_err=0, busy=0.
  - State LOCKWAIT, counter 0, lock synchroniser cleared.
- Lock qualification (separate from the request FSM):
  - lock_s = pll_lock after the 2-flop synchroniser.
  - Counter increments while lock_s=1 and saturates at LOCK_CYCLES.
  - Any cycle with lock_s=0 clears the counter and asserts sys_reset the next cycle, from any state.
  - sys_reset falls on the cycle after the counter reaches LOCK_CYCLES. Release latency from pll_lock rising is 2 + LOCK_CYCLES + 1 cycles.
- FSM states: LOCKWAIT, IDLE, DETACH, BOOT.
  - LOCKWAIT: usb_pu=0. Go to IDLE when sys_reset deasserts.
  - IDLE: usb_pu=1, req_ready=1. On req_valid & req_ready:
    - Image index = req_auto ? DEFAULT_IMAGE : req_image.
    - If index >= IMAGE_COUNT: pulse req_err for 1 cycle and stay in IDLE.
    - Otherwise: latch the index into boot_sel, clear the counter, go to DETACH.
  - DETACH: usb_pu=0, busy=1. Counter increments; at DETACH_CYCLES-1 go to BOOT.
  - BOOT: usb_pu=0, busy=1, boot=1 for exactly BOOT_HOLD_CYCLES cycles.
    - After that, stay in BOOT with boot=0 (terminal; the device reconfigures).
    - Only reset_n or a lock loss leaves BOOT.
  - Lock loss in IDLE, DETACH or BOOT: go to LOCKWAIT.
    - boot=0 immediately on the next cycle.
    - boot_sel retains its value; any pending reboot is aborted.
- Request ordering:
  - req_valid while req_ready=0 is ignored: no req_err, no queuing.
  - boot_sel is stable for the whole of DETACH and BOOT; it changes only on an accepted request.
- Counter arithmetic: unsigned CNT_W-bit, no wrap; compares use ==. Never reaches 2^CNT_W.
- Registered outputs:
  - All outputs are registered, with no combinational input-to-output paths.
  - Exception: req_ready decodes registered state only.
- reset_n assertion mid-DETACH or mid-BOOT aborts immediately: boot=0, usb_pu=0.

Test Plan:
- Lock bring-up:
  - Stimulus: reset_n released; pll_lock rises at cycle 10 with LOCK_CYCLES=8.
  - Response: sys_reset falls at cycle 10+2+8+1=21; usb_pu=1 and req_ready=1 on the following cycle.
- Lock glitch:
  - Stimulus: pll_lock drops for 1 cycle after 5 stable cycles (LOCK_CYCLES=8).
  - Response: counter restarts; sys_reset stays 1 until 8 fresh stable cycles.
- Normal reboot:
  - Stimulus: req_image=2, DETACH_CYCLES=16, BOOT_HOLD_CYCLES=4.
  - Response: boot_sel=2 on the next cycle; usb_pu=0 for 16 cycles; then boot=1 for exactly 4 cycles; then boot=0 with busy=1.
- Auto request and bad index:
  - Stimulus: req_auto=1 with req_image=3 and DEFAULT_IMAGE=1 → response: boot_sel=1.
  - Stimulus: IMAGE_COUNT=2, req_image=3 → response: req_err pulses 1 cycle, state stays IDLE, usb_pu stays 1.
- Abort on lock loss:
  - Stimulus: pll_lock falls at DETACH cycle 5.
  - Response: state LOCKWAIT, sys_reset=1, boot never asserted, boot_sel unchanged.
- Async reset mid-BOOT:
  - Stimulus: reset_n low while boot=1.
  - Response: boot=0, sys_reset=1, boot_sel=DEFAULT_IMAGE in the same cycle, with no clock edge required.
